instruction_fetch: RTL and testbench

- Fetch stage directly upstream of instruction_decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake with variable latency.
- Registers each returned 32-bit word plus its PC and presents them to decode over a valid/ready handshake.
- Supports stall (enable low), back-pressure and PC redirect (jump/branch target load) with flush of any in-flight fetch.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset instruction
// and program-counter constants.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding word read over req/ack and
// presents the returned word plus its PC to decode through a one-entry buffer.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic               flush_q, flush_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;

  logic [ADDR_W-1:0]  target;
  logic               unused_redirect_lsb;

  assign target              = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    flush_d = flush_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = target;
        if (en) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redirect_valid ? target : pc_q;
        end
      end

      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d    = target;
            flush_d = 1'b0;
            state_d = en ? REQ : IDLE;
            req_d   = en;
            addr_d  = target;
          end else if (flush_q) begin
            // Word belongs to the pre-redirect stream; discard and refetch.
            flush_d = 1'b0;
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_STEP);
            state_d = HOLD;
            req_d   = 1'b0;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until ack, so only the PC moves now.
          pc_d    = target;
          flush_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = en ? REQ : IDLE;
          req_d   = en;
          addr_d  = target;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = en ? REQ : IDLE;
          req_d   = en;
          addr_d  = pc_q;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(NOP_INSTR);
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, slow memory with
// back-pressure, redirect flush, reset mid-wait, en gating and PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, redirect_valid, imem_ack, instr_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, instr_pc;

  logic        en_b, ack_b, ready_b, redir_b;
  logic [31:0] redir_pc_b, rdata_b;
  logic        req_b, valid_b;
  logic [31:0] addr_b, instr_b, ipc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .en(en_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b),
    .instr_valid(valid_b), .instr_ready(ready_b),
    .instruction(instr_b), .instr_pc(ipc_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    en_b = 1'b0; ack_b = 1'b0; ready_b = 1'b0; redir_b = 1'b0;
    redir_pc_b = 32'h0; rdata_b = 32'h0;
    step();
    step();

    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_ipc",   instr_pc, 32'h0);
    chk("rst_b_addr", addr_b, 32'hFFFF_FFFC);

    // Zero-wait memory, decoder always ready.
    rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      chk("seq_req",  {31'b0, imem_req}, 32'h1);
      chk("seq_addr", imem_addr, a);
      imem_ack = 1'b1; imem_rdata = a ^ 32'hA5A5_0000;
      step();
      imem_ack = 1'b0;
      chk("seq_valid", {31'b0, instr_valid}, 32'h1);
      chk("seq_ipc",   instr_pc, a);
      chk("seq_instr", instruction, a ^ 32'hA5A5_0000);
      chk("seq_noreq", {31'b0, imem_req}, 32'h0);
      step();
    end
    chk("seq_next_addr", imem_addr, 32'h10);

    // Reset while waiting on ack for addr 16; late ack must be ignored.
    rst = 1'b1;
    step();
    chk("rstw_req",   {31'b0, imem_req}, 32'h0);
    chk("rstw_addr",  imem_addr, 32'h0);
    chk("rstw_valid", {31'b0, instr_valid}, 32'h0);
    chk("rstw_instr", instruction, 32'h0000_0013);
    rst = 1'b0; en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, instr_valid}, 32'h0);
    chk("late_ack_req",   {31'b0, imem_req}, 32'h0);
    chk("late_ack_instr", instruction, 32'h0000_0013);

    // Slow memory and decoder back-pressure.
    en = 1'b1; instr_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",  {31'b0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0040_0093;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, instr_valid}, 32'h1);
      chk("bp_instr", instruction, 32'h0040_0093);
      chk("bp_ipc",   instr_pc, 32'h0);
      chk("bp_noreq", {31'b0, imem_req}, 32'h0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk("bp_rel_valid", {31'b0, instr_valid}, 32'h0);
    chk("bp_rel_addr",  imem_addr, 32'h4);

    // Redirect while waiting on the fetch at addr 8.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0004;
    step();
    imem_ack = 1'b0;
    step();
    chk("rd_addr8", imem_addr, 32'h8);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("rd_hold_req",  {31'b0, imem_req}, 32'h1);
    chk("rd_hold_addr", imem_addr, 32'h8);
    step();
    chk("rd_hold_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    chk("rd_drop_valid", {31'b0, instr_valid}, 32'h0);
    chk("rd_new_req",    {31'b0, imem_req}, 32'h1);
    chk("rd_new_addr",   imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0;
    chk("rd_valid", {31'b0, instr_valid}, 32'h1);
    chk("rd_ipc",   instr_pc, 32'h100);
    chk("rd_instr", instruction, 32'h1111_1111);

    // en dropped in HOLD with decoder ready, then re-raised.
    en = 1'b0;
    step();
    chk("en_lo_valid", {31'b0, instr_valid}, 32'h0);
    chk("en_lo_req",   {31'b0, imem_req}, 32'h0);
    step();
    step();
    chk("en_lo_req2", {31'b0, imem_req}, 32'h0);
    en = 1'b1;
    step();
    chk("en_hi_req",  {31'b0, imem_req}, 32'h1);
    chk("en_hi_addr", imem_addr, 32'h104);

    // Redirect in HOLD discards the held word.
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    instr_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("hrd_valid_pre", {31'b0, instr_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("hrd_valid", {31'b0, instr_valid}, 32'h0);
    chk("hrd_instr", instruction, 32'h2222_2222);
    chk("hrd_req",   {31'b0, imem_req}, 32'h1);
    chk("hrd_addr",  imem_addr, 32'h200);

    // PC wrap on the instance reset to the last word.
    en_b = 1'b1; ready_b = 1'b1;
    step();
    chk("wrap_req",  {31'b0, req_b}, 32'h1);
    chk("wrap_addr", addr_b, 32'hFFFF_FFFC);
    ack_b = 1'b1; rdata_b = 32'h1234_5678;
    step();
    ack_b = 1'b0;
    chk("wrap_valid", {31'b0, valid_b}, 32'h1);
    chk("wrap_ipc",   ipc_b, 32'hFFFF_FFFC);
    chk("wrap_instr", instr_b, 32'h1234_5678);
    step();
    chk("wrap_next_addr", addr_b, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
